truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequencer for a 4-input combinational logic block under test.
- On a start pulse it drives all 2^N input vectors in ascending order. It waits a programmable settle time per vector, then samples the block's output f.
- The result is assembled into a 2^N-bit truth-table word plus a ones count, and completion is signalled with a done pulse.
- Sits beside the combinational block in lab designs, replacing hand-written exhaustive stimulus.

Parameters:
- N, 4, number of inputs driven on vec (2 to 6 supported).
- SETTLE, 1, extra hold cycles per vector before sampling (0 allowed; 0 means sample in the same cycle the vector is applied).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request a sweep; honoured only in IDLE.
- vec  out  N  input vector to the block; vec[N-1] drives a, vec[0] drives the last input.
- f_in  in  1  block output being sampled.
- busy  out  1  high while a sweep is in progress (RUN).
- done  out  1  one-cycle pulse when the table is complete.
- table_out  out  2^N  bit i holds f sampled with vec==i.
- ones_count  out  N+1  number of 1 bits in table_out.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - vec=0, busy=0, done=0, table_out=0, ones_count=0, settle counter=0.
  - Reset has priority over every other event, including mid-sweep; no partial result is retained.
- States: IDLE, RUN, DONE.
- IDLE:
  - vec=0, busy=0.
  - If start=1 at an edge: go to RUN, clear table_out and ones_count, set vec=0 and cnt=0.
- RUN:
  - busy=1. cnt increments each cycle.
  - When cnt==SETTLE: table_out[vec] <= f_in, and ones_count increments by f_in.
  - If vec==2^N-1 at that point, go to DONE; otherwise vec increments and cnt resets to 0.
  - Each vector is held exactly SETTLE+1 cycles.
- DONE:
  - done=1 and busy=0 for exactly one cycle; vec returns to 0.
  - Next state is IDLE unconditionally.
- Timing: if start is sampled at edge k, busy rises after edge k, the last sample occurs at edge k+2^N*(SETTLE+1), and done is high during the following cycle. Default sweep: 32 RUN cycles.
- start handling:
  - start while in RUN or DONE is ignored; it is not queued.
  - start held high continuously gives back-to-back sweeps separated by one DONE cycle and one IDLE cycle.
- table_out and ones_count hold their final values until the next accepted start or reset.
- ones_count reaches 2^N when f is all-ones, hence N+1 bits; it never wraps.
- f_in is sampled only on sample cycles; changes at other times have no effect.

Optional Feature:
- Macro: TRUTH_TABLE_SWEEPER_COMPARE_EN.
- When defined, the block adds three ports:
  - expected (in, 2^N): reference table, sampled once when start is accepted.
  - mismatch (out, 1): set in DONE if table_out != expected, held until the next accepted start or reset; reset value 0.
  - first_bad (out, N): lowest index i where the bits differ; 0 if there is no mismatch.
  - The comparison is done per sample as each bit is captured, with no extra latency; mismatch becomes visible in the DONE cycle.
- When not defined, these ports and their logic do not exist, and the remaining behaviour is identical.

Test Plan:
- Function check: N=4, SETTLE=1, f=(a&b)|(c&d) modelled combinationally from vec, single start → done after 33 cycles, table_out=16'hF888, ones_count=7, busy high for exactly 32 cycles.
- Constant inputs: f_in tied 0 → table_out=16'h0000, ones_count=0. f_in tied 1 → table_out=16'hFFFF, ones_count=16.
- Hold timing: SETTLE=0 with f=vec[0] → table_out=16'hAAAA, done 17 cycles after start. SETTLE=3 → every vec value held 4 cycles, done 65 cycles after start.
- Reset mid-sweep: assert rst_n=0 for one edge while vec==5 → next cycle vec=0, busy=0, table_out=0. A following start then completes a normal sweep.
- start handling: pulse start again mid-RUN → ignored, done occurs at the original time. Hold start high for 3 sweeps → done pulses spaced 34 cycles apart (SETTLE=1).
- Compare feature (with TRUTH_TABLE_SWEEPER_COMPARE_EN): expected=16'hF888 with f forced wrong at vec 3 and vec 9 → mismatch=1, first_bad=3. With correct f → mismatch=0, first_bad=0.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive truth-table sweeper for an N-input combinational block
//
// On an accepted start, drives vec through 0..2^N-1 in ascending order. Each vector is held
// SETTLE+1 cycles and f_in is sampled on the last of those cycles. The samples build table_out
// (bit i = f with vec==i) and ones_count. A one-cycle done pulse marks completion.
//
// Ports:
//   clk, rst_n     clock (rising edge) and synchronous active-low reset
//   start          sweep request, honoured only in IDLE
//   vec            vector applied to the block under test (vec[N-1] = first input)
//   f_in           block output being sampled
//   busy           high during the sweep
//   done           one-cycle completion pulse
//   table_out      captured truth table
//   ones_count     number of ones in table_out
// Optional (TRUTH_TABLE_SWEEPER_COMPARE_EN defined):
//   expected       reference table, captured when start is accepted
//   mismatch       table_out differs from expected (valid from the DONE cycle)
//   first_bad      lowest differing index, 0 when there is no mismatch
module truth_table_sweeper #(
    parameter int N      = 4,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N-1:0]      vec,
    input  logic              f_in,
    output logic              busy,
    output logic              done,
    output logic [2**N-1:0]   table_out,
    output logic [N:0]        ones_count
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
    ,
    input  logic [2**N-1:0]   expected,
    output logic              mismatch,
    output logic [N-1:0]      first_bad
`endif
);

    localparam int W  = 2**N;
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [N-1:0]  VEC_ONE  = N'(1);
    localparam logic [N-1:0]  VEC_LAST = {N{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    vec_q, vec_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    table_q, table_d;
    logic [N:0]      ones_q, ones_d;

`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
    logic [W-1:0]    exp_q, exp_d;
    logic            bad_q, bad_d;
    logic            mismatch_q, mismatch_d;
    logic [N-1:0]    first_bad_q, first_bad_d;
`endif

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        ones_d  = ones_q;
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
        exp_d       = exp_q;
        bad_d       = bad_q;
        mismatch_d  = mismatch_q;
        first_bad_d = first_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                vec_d = '0;
                cnt_d = '0;
                if (start) begin
                    state_d = S_RUN;
                    table_d = '0;
                    ones_d  = '0;
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
                    exp_d       = expected;
                    bad_d       = 1'b0;
                    mismatch_d  = 1'b0;
                    first_bad_d = '0;
`endif
                end
            end
            S_RUN: begin
                if (cnt_q == SETTLE_C) begin
                    table_d[vec_q] = f_in;
                    ones_d         = ones_q + {{N{1'b0}}, f_in};
                    cnt_d          = '0;
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
                    // Only the first differing index is kept; vectors ascend, so it is the lowest.
                    if (!bad_q && (f_in != exp_q[vec_q])) begin
                        bad_d       = 1'b1;
                        first_bad_d = vec_q;
                    end
`endif
                    if (vec_q == VEC_LAST) begin
                        state_d = S_DONE;
                        vec_d   = '0;
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
                        mismatch_d = bad_d;
`endif
                    end else begin
                        vec_d = vec_q + VEC_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                vec_d   = '0;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                vec_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            table_q <= '0;
            ones_q  <= '0;
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
            exp_q       <= '0;
            bad_q       <= 1'b0;
            mismatch_q  <= 1'b0;
            first_bad_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            ones_q  <= ones_d;
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
            exp_q       <= exp_d;
            bad_q       <= bad_d;
            mismatch_q  <= mismatch_d;
            first_bad_q <= first_bad_d;
`endif
        end
    end

    assign vec        = vec_q;
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign table_out  = table_q;
    assign ones_count = ones_q;
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
    assign mismatch   = mismatch_q;
    assign first_bad  = first_bad_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - directed self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  start_v;
    logic [2:0][2:0] mode_v;

    logic [3:0]  vec0, vec1, vec2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [15:0] tab0, tab1, tab2;
    logic [4:0]  ones0, ones1, ones2;
    logic        f0, f1, f2;

    logic [2:0]        busy_v, done_v;
    logic [2:0][3:0]   vec_v;
    logic [2:0][15:0]  tab_v;
    logic [2:0][4:0]   ones_v;

    assign busy_v = {busy2, busy1, busy0};
    assign done_v = {done2, done1, done0};
    assign vec_v  = {vec2, vec1, vec0};
    assign tab_v  = {tab2, tab1, tab0};
    assign ones_v = {ones2, ones1, ones0};

    int n_cmp = 0;
    int n_bad = 0;
    int hold_cnt [16];
    bit order_ok;

    // 0: (a&b)|(c&d)  1: const 0  2: const 1  3: d  4: mode 0 flipped at vec 3 and 9
    function automatic logic f_model(input logic [2:0] m, input logic [3:0] v);
        logic g;
        g = (v[3] & v[2]) | (v[1] & v[0]);
        case (m)
            3'd0: return g;
            3'd1: return 1'b0;
            3'd2: return 1'b1;
            3'd3: return v[0];
            3'd4: return g ^ ((v == 4'd3) || (v == 4'd9));
            default: return 1'b0;
        endcase
    endfunction

    assign f0 = f_model(mode_v[0], vec0);
    assign f1 = f_model(mode_v[1], vec1);
    assign f2 = f_model(mode_v[2], vec2);

`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
    logic [15:0] exp_in;
    logic        mis0, mis1, mis2;
    logic [3:0]  fb0, fb1, fb2;
`endif

    truth_table_sweeper #(.N(4), .SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .vec(vec0), .f_in(f0),
        .busy(busy0), .done(done0), .table_out(tab0), .ones_count(ones0)
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
        , .expected(exp_in), .mismatch(mis0), .first_bad(fb0)
`endif
    );

    truth_table_sweeper #(.N(4), .SETTLE(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .vec(vec1), .f_in(f1),
        .busy(busy1), .done(done1), .table_out(tab1), .ones_count(ones1)
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
        , .expected(exp_in), .mismatch(mis1), .first_bad(fb1)
`endif
    );

    truth_table_sweeper #(.N(4), .SETTLE(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .vec(vec2), .f_in(f2),
        .busy(busy2), .done(done2), .table_out(tab2), .ones_count(ones2)
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
        , .expected(exp_in), .mismatch(mis2), .first_bad(fb2)
`endif
    );

    // Starts a sweep on unit u from a negedge; cyc counts edges from the start edge (1) to the
    // edge after which done is seen. Optionally re-pulses start at cycle pulse_at.
    task automatic sweep(input int u, input int pulse_at, output int cyc, output int busy_n);
        bit got;
        bit seen;
        logic [3:0] prev;
        for (int i = 0; i < 16; i++) hold_cnt[i] = 0;
        order_ok = 1'b1;
        seen = 1'b0;
        prev = 4'd0;
        got = 1'b0;
        cyc = 0;
        busy_n = 0;
        start_v[u] = 1'b1;
        while (!got && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start_v[u] = (cyc == pulse_at);
            if (busy_v[u]) begin
                busy_n++;
                hold_cnt[vec_v[u]]++;
                if (seen && vec_v[u] != prev && vec_v[u] != prev + 4'd1) order_ok = 1'b0;
                prev = vec_v[u];
                seen = 1'b1;
            end
            if (done_v[u]) got = 1'b1;
        end
        start_v[u] = 1'b0;
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL sweep_timeout unit=%0d: done=0 after %0d cycles, required done=1", u, cyc);
        end
        @(negedge clk);
        n_cmp++;
        if ({done_v[u], busy_v[u]} !== 2'b00) begin
            n_bad++;
            $display("FAIL done_pulse unit=%0d: done,busy=%b%b one cycle later, required 00", u, done_v[u], busy_v[u]);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (vec0 !== 4'd0)   begin n_bad++; $display("FAIL rst_vec: got %0d, required 0", vec0); end
        n_cmp++; if (busy0 !== 1'b0)  begin n_bad++; $display("FAIL rst_busy: got %b, required 0", busy0); end
        n_cmp++; if (done0 !== 1'b0)  begin n_bad++; $display("FAIL rst_done: got %b, required 0", done0); end
        n_cmp++; if (tab0 !== 16'h0)  begin n_bad++; $display("FAIL rst_table: got %h, required 0000", tab0); end
        n_cmp++; if (ones0 !== 5'd0)  begin n_bad++; $display("FAIL rst_ones: got %0d, required 0", ones0); end
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
        n_cmp++; if (mis0 !== 1'b0)   begin n_bad++; $display("FAIL rst_mismatch: got %b, required 0", mis0); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_function;
        int cyc, bn;
        mode_v[0] = 3'd0;
        sweep(0, -1, cyc, bn);
        n_cmp++; if (cyc !== 33)        begin n_bad++; $display("FAIL func_latency: got %0d, required 33", cyc); end
        n_cmp++; if (bn !== 32)         begin n_bad++; $display("FAIL func_busy_len: got %0d, required 32", bn); end
        n_cmp++; if (tab0 !== 16'hF888) begin n_bad++; $display("FAIL func_table: got %h, required f888", tab0); end
        n_cmp++; if (ones0 !== 5'd7)    begin n_bad++; $display("FAIL func_ones: got %0d, required 7", ones0); end
        n_cmp++; if (!order_ok)         begin n_bad++; $display("FAIL func_order: vec not ascending by 1"); end
    endtask

    task automatic test_constant;
        int cyc, bn;
        mode_v[0] = 3'd1;
        sweep(0, -1, cyc, bn);
        n_cmp++; if (tab0 !== 16'h0000) begin n_bad++; $display("FAIL zero_table: got %h, required 0000", tab0); end
        n_cmp++; if (ones0 !== 5'd0)    begin n_bad++; $display("FAIL zero_ones: got %0d, required 0", ones0); end
        mode_v[0] = 3'd2;
        sweep(0, -1, cyc, bn);
        n_cmp++; if (tab0 !== 16'hFFFF) begin n_bad++; $display("FAIL ones_table: got %h, required ffff", tab0); end
        n_cmp++; if (ones0 !== 5'd16)   begin n_bad++; $display("FAIL ones_count16: got %0d, required 16", ones0); end
    endtask

    task automatic test_hold;
        int cyc, bn;
        bit ok;
        mode_v[1] = 3'd3;
        sweep(1, -1, cyc, bn);
        n_cmp++; if (cyc !== 17)        begin n_bad++; $display("FAIL s0_latency: got %0d, required 17", cyc); end
        n_cmp++; if (tab1 !== 16'hAAAA) begin n_bad++; $display("FAIL s0_table: got %h, required aaaa", tab1); end
        n_cmp++; if (ones1 !== 5'd8)    begin n_bad++; $display("FAIL s0_ones: got %0d, required 8", ones1); end
        mode_v[2] = 3'd0;
        sweep(2, -1, cyc, bn);
        ok = 1'b1;
        for (int i = 0; i < 16; i++) if (hold_cnt[i] != 4) ok = 1'b0;
        n_cmp++; if (cyc !== 65)        begin n_bad++; $display("FAIL s3_latency: got %0d, required 65", cyc); end
        n_cmp++; if (!ok)               begin n_bad++; $display("FAIL s3_hold: vec0 held %0d cycles, required 4 for every vec", hold_cnt[0]); end
        n_cmp++; if (!order_ok)         begin n_bad++; $display("FAIL s3_order: vec not ascending by 1"); end
        n_cmp++; if (tab2 !== 16'hF888) begin n_bad++; $display("FAIL s3_table: got %h, required f888", tab2); end
    endtask

    task automatic test_reset_mid;
        int cyc, bn;
        mode_v[0] = 3'd0;
        start_v[0] = 1'b1;
        cyc = 0;
        while (vec0 !== 4'd5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start_v[0] = 1'b0;
        end
        n_cmp++; if (vec0 !== 4'd5) begin n_bad++; $display("FAIL mid_reach5: vec=%0d, required 5", vec0); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (vec0 !== 4'd0)   begin n_bad++; $display("FAIL mid_vec: got %0d, required 0", vec0); end
        n_cmp++; if (busy0 !== 1'b0)  begin n_bad++; $display("FAIL mid_busy: got %b, required 0", busy0); end
        n_cmp++; if (tab0 !== 16'h0)  begin n_bad++; $display("FAIL mid_table: got %h, required 0000", tab0); end
        n_cmp++; if (ones0 !== 5'd0)  begin n_bad++; $display("FAIL mid_ones: got %0d, required 0", ones0); end
        @(negedge clk);
        sweep(0, -1, cyc, bn);
        n_cmp++; if (cyc !== 33)        begin n_bad++; $display("FAIL post_rst_latency: got %0d, required 33", cyc); end
        n_cmp++; if (tab0 !== 16'hF888) begin n_bad++; $display("FAIL post_rst_table: got %h, required f888", tab0); end
    endtask

    task automatic test_start_ignored;
        int cyc, bn;
        mode_v[0] = 3'd0;
        sweep(0, 10, cyc, bn);
        n_cmp++; if (cyc !== 33) begin n_bad++; $display("FAIL ign_latency: got %0d, required 33", cyc); end
        n_cmp++; if (bn !== 32)  begin n_bad++; $display("FAIL ign_busy_len: got %0d, required 32", bn); end
        repeat (3) @(negedge clk);
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL ign_not_queued: busy=%b, required 0", busy0); end
    endtask

    task automatic test_back_to_back;
        int cyc, nd;
        int t [3];
        for (int i = 0; i < 3; i++) t[i] = 0;
        mode_v[0] = 3'd0;
        cyc = 0;
        nd = 0;
        start_v[0] = 1'b1;
        while (nd < 3 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (done0) begin
                t[nd] = cyc;
                nd++;
                if (nd == 3) start_v[0] = 1'b0;
            end
        end
        start_v[0] = 1'b0;
        n_cmp++; if (nd !== 3)          begin n_bad++; $display("FAIL b2b_count: got %0d done pulses, required 3", nd); end
        n_cmp++; if (t[0] !== 33)       begin n_bad++; $display("FAIL b2b_first: got %0d, required 33", t[0]); end
        n_cmp++; if (t[1] - t[0] !== 34) begin n_bad++; $display("FAIL b2b_gap1: got %0d, required 34", t[1] - t[0]); end
        n_cmp++; if (t[2] - t[1] !== 34) begin n_bad++; $display("FAIL b2b_gap2: got %0d, required 34", t[2] - t[1]); end
        n_cmp++; if (tab0 !== 16'hF888) begin n_bad++; $display("FAIL b2b_table: got %h, required f888", tab0); end
        repeat (2) @(negedge clk);
        n_cmp++; if (busy0 !== 1'b0)    begin n_bad++; $display("FAIL b2b_stop: busy=%b, required 0", busy0); end
    endtask

`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
    task automatic test_compare;
        int cyc, bn;
        exp_in = 16'hF888;
        mode_v[0] = 3'd4;
        sweep(0, -1, cyc, bn);
        n_cmp++; if (tab0 !== 16'hFA80) begin n_bad++; $display("FAIL cmp_bad_table: got %h, required fa80", tab0); end
        n_cmp++; if (mis0 !== 1'b1)     begin n_bad++; $display("FAIL cmp_bad_mismatch: got %b, required 1", mis0); end
        n_cmp++; if (fb0 !== 4'd3)      begin n_bad++; $display("FAIL cmp_bad_first: got %0d, required 3", fb0); end
        mode_v[0] = 3'd0;
        sweep(0, -1, cyc, bn);
        n_cmp++; if (mis0 !== 1'b0)     begin n_bad++; $display("FAIL cmp_ok_mismatch: got %b, required 0", mis0); end
        n_cmp++; if (fb0 !== 4'd0)      begin n_bad++; $display("FAIL cmp_ok_first: got %0d, required 0", fb0); end
    endtask
`endif

    initial begin
        rst_n   = 1'b0;
        start_v = 3'b000;
        mode_v  = '0;
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
        exp_in  = 16'h0000;
`endif
        test_reset();
        test_function();
        test_constant();
        test_hold();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
`ifdef TRUTH_TABLE_SWEEPER_COMPARE_EN
        test_compare();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
